regfile_write_arbiter: RTL and testbench

//  Owns the single register-file write port and shares it between the pipeline writeback stage (WB)
//  and the long-latency unit result path (LU, multi-cycle mul/div).
//  WB has fixed priority. LU results are buffered in a small FIFO and drained in idle WB cycles.
//  A starvation counter requests a pipeline bubble. A 16-bit scoreboard tracks registers owed an LU result.

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_if.sv | 41 ++++
 rtl/regfile_write_arbiter_rfw_result_fifo.sv | 68 ++++++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths, defaults and entry type for the RF write arbiter
// Shared constants for the register-file write path.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry
//   DEF_FIFO_DEPTH             : default LU result buffer depth (power of two, >= 2)
//   DEF_STARVE_LIMIT           : default starvation threshold for the pipeline hold request
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned ADDR_W           = 4;
  localparam int unsigned NUM_REGS         = 1 << ADDR_W;
  localparam int unsigned DEF_FIFO_DEPTH   = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // One buffered LU result: destination register plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rfw_entry_t;

  localparam int unsigned ENTRY_W = $bits(rfw_entry_t);

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - bus bundle between the pipeline/LU and the RF write arbiter
// Signals:
//   wb_we/wb_addr/wb_data         writeback stage write request
//   lu_valid/lu_ready/lu_addr/... long-latency unit result handshake
//   issue_en/issue_addr           long op issued, marks destination busy
//   rf_we/rf_waddr/rf_wdata       register-file write port (registered)
//   end_write/end_reg             write-completed pulse and register
//   pipe_hold                     bubble request to the pipeline
//   busy_mask                     registers still owed an LU result
// master: pipeline/LU side. slave: the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                wb_we;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                lu_valid;
  logic                lu_ready;
  logic [ADDR_W-1:0]   lu_addr;
  logic [DATA_W-1:0]   lu_data;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_addr;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                end_write;
  logic [ADDR_W-1:0]   end_reg;
  logic                pipe_hold;
  logic [NUM_REGS-1:0] busy_mask;

  modport master (
    output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, issue_en, issue_addr,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, end_write, end_reg, pipe_hold, busy_mask
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, issue_en, issue_addr,
    output lu_ready, rf_we, rf_waddr, rf_wdata, end_write, end_reg, pipe_hold, busy_mask
  );

endinterface

// File: rtl/regfile_write_arbiter_rfw_result_fifo.sv
// rtl/regfile_write_arbiter_rfw_result_fifo.sv - synchronous FIFO buffering LU results
// Ports:
//   clk_i, rst_n_i   clock, async active-low clear (flushes pointers and count)
//   push_i, push_data_i  write an entry (ignored when full)
//   pop_i            remove the head entry (ignored when empty)
//   head_o           current head entry (valid when !empty_o)
//   full_o, empty_o  derived from the registered occupancy count
module rfw_result_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between WB and LU results
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  async active-low reset; flushes buffered LU results and the scoreboard
//   bus      regfile_write_arbiter_if.slave (WB request, LU handshake, issue marking,
//            registered RF write port, end pulse, pipe hold, busy mask)
// WB has fixed priority; LU results queue in rfw_result_fifo and drain on idle WB cycles.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  regfile_write_arbiter_if.slave    bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  rfw_entry_t          push_entry;
  rfw_entry_t          head_entry;
  logic [ENTRY_W-1:0]  head_bits;
  logic                fifo_full, fifo_empty;
  logic                push, pop;

  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                hold_q, hold_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign push_entry = '{addr: bus.lu_addr, data: bus.lu_data};
  assign head_entry = head_bits;
  assign push       = bus.lu_valid & ~fifo_full;
  // The FIFO drains only on cycles WB leaves the port free; an entry pushed this
  // cycle is not yet visible, so there is no LU bypass.
  assign pop        = ~bus.wb_we & ~fifo_empty;

  rfw_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    rf_we_d    = bus.wb_we | pop;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (bus.wb_we) begin
      rf_waddr_d = bus.wb_addr;
      rf_wdata_d = bus.wb_data;
    end else if (pop) begin
      rf_waddr_d = head_entry.addr;
      rf_wdata_d = head_entry.data;
    end

    // Counts cycles a buffered result waits behind WB; saturates at the limit.
    starve_d = starve_q;
    if (fifo_empty || pop)          starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
    hold_d = (starve_d >= STARVE_MAX);

    // Issue is applied after the pop clear so a same-cycle set on that bit wins.
    busy_d = busy_q;
    if (pop)          busy_d[head_entry.addr] = 1'b0;
    if (bus.issue_en) busy_d[bus.issue_addr]  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      starve_q   <= starve_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.lu_ready  = ~fifo_full;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.end_write = rf_we_q;
  assign bus.end_reg   = rf_waddr_q;
  assign bus.pipe_hold = hold_q;
  assign bus.busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        we;
    logic        ready;
    logic        hold;
    logic [15:0] busy;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();
  regfile_write_arbiter dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit lu_accepted = 1'b0;

  wr_t  wq[$];
  st_t  status_q[$];
  wr_t  m_fifo[$];
  int   m_starve = 0;
  logic [15:0] m_busy = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic wbe, input logic [3:0] wba, input logic [15:0] wbd,
                        input logic luv, input logic [3:0] lua, input logic [15:0] lud,
                        input logic ise, input logic [3:0] isa);
    bus.wb_we = wbe; bus.wb_addr = wba; bus.wb_data = wbd;
    bus.lu_valid = luv; bus.lu_addr = lua; bus.lu_data = lud;
    bus.issue_en = ise; bus.issue_addr = isa;
  endtask

  // Reference model: applies this cycle's inputs, queues what the DUT must show
  // after the coming edge, then advances to just after that edge.
  task automatic step();
    int  sz;
    bit  acc;
    bit  popped;
    wr_t e;
    st_t s;
    sz     = m_fifo.size();
    acc    = bus.lu_valid && (sz < DEPTH);
    popped = 1'b0;
    e      = '0;
    if (bus.wb_we) wq.push_back('{addr: bus.wb_addr, data: bus.wb_data});
    else if (sz > 0) begin
      e = m_fifo.pop_front();
      wq.push_back(e);
      popped = 1'b1;
    end
    if (acc) m_fifo.push_back('{addr: bus.lu_addr, data: bus.lu_data});
    if (sz == 0 || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (popped) m_busy[e.addr] = 1'b0;
    if (bus.issue_en) m_busy[bus.issue_addr] = 1'b1;
    s.we    = bus.wb_we | popped;
    s.ready = (m_fifo.size() < DEPTH);
    s.hold  = (m_starve >= LIMIT);
    s.busy  = m_busy;
    status_q.push_back(s);
    lu_accepted = acc;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    st_t s;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s.we = 0; s.ready = 1; s.hold = 0; s.busy = '0;
    status_q.push_back(s);
    mon_en = 1'b1;
  endtask

  // Called just after an edge: asserts reset mid-cycle and checks outputs at once.
  task automatic do_reset();
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_rf_we",     32'(bus.rf_we),     0);
    chk("rst_end_write", 32'(bus.end_write), 0);
    chk("rst_busy",      32'(bus.busy_mask), 0);
    chk("rst_lu_ready",  32'(bus.lu_ready),  1);
    chk("rst_pipe_hold", 32'(bus.pipe_hold), 0);
    status_q.delete();
    wq.delete();
    m_fifo.delete();
    m_starve = 0;
    m_busy = '0;
    lu_accepted = 1'b0;
    release_reset();
  endtask

  logic [3:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    st_t s;
    wr_t w;
    if (!mon_en) begin
      last_addr = '0;
      last_data = '0;
    end else if (status_q.size() == 0) begin
      chk("status_queue_underrun", 0, 1);
    end else begin
      s = status_q.pop_front();
      chk("rf_we",     32'(bus.rf_we),     32'(s.we));
      chk("end_write", 32'(bus.end_write), 32'(s.we));
      chk("lu_ready",  32'(bus.lu_ready),  32'(s.ready));
      chk("pipe_hold", 32'(bus.pipe_hold), 32'(s.hold));
      chk("busy_mask", 32'(bus.busy_mask), 32'(s.busy));
      if (bus.rf_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(w.addr));
          chk("rf_wdata", 32'(bus.rf_wdata), 32'(w.data));
          chk("end_reg",  32'(bus.end_reg),  32'(w.addr));
          last_addr = w.addr;
          last_data = w.data;
        end
      end else begin
        chk("rf_waddr_hold", 32'(bus.rf_waddr), 32'(last_addr));
        chk("rf_wdata_hold", 32'(bus.rf_wdata), 32'(last_data));
      end
    end
  end

  initial begin
    int wb_pct;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    release_reset();

    // WB only.
    set_in(1, 4'd3, 16'h1234, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Issue r5, then its LU result drains with WB idle.
    set_in(0, 0, 0, 0, 0, 0, 1, 4'd5); step();
    set_in(0, 0, 0, 1, 4'd5, 16'h00FF, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // Full: WB holds the port, two results fill the FIFO, a third waits.
    set_in(1, 4'd1, 16'hA001, 1, 4'd8, 16'h0801, 0, 0); step();
    set_in(1, 4'd2, 16'hA002, 1, 4'd9, 16'h0902, 0, 0); step();
    set_in(1, 4'd3, 16'hA003, 1, 4'd10, 16'h0A03, 0, 0);
    repeat (2) step();
    bus.wb_we = 1'b0;
    for (int k = 0; k < 6 && !lu_accepted; k++) step();
    chk("third_lu_accepted", 32'(lu_accepted), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (4) step();

    // Starvation: one entry stuck behind continuous WB, then WB drops.
    set_in(1, 4'd4, 16'hB000, 1, 4'd11, 16'h0B0B, 0, 0); step();
    for (int k = 0; k < 6; k++) begin
      set_in(1, 4'(k), 16'(16'hB100 + k), 0, 0, 0, 0, 0); step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // Collision: pop of r7 coincides with a new issue to r7.
    set_in(1, 4'd0, 16'hC000, 1, 4'd7, 16'h0707, 1, 4'd7); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 4'd7); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // Reset mid-drain with two entries buffered.
    set_in(1, 4'd6, 16'hD000, 1, 4'd12, 16'h0C0C, 0, 0); step();
    set_in(1, 4'd6, 16'hD001, 1, 4'd13, 16'h0D0D, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    do_reset();
    repeat (3) step();

    // Randomized traffic with varying WB pressure and one reset mid-run.
    for (int i = 0; i < 600; i++) begin
      wb_pct = (i < 200) ? 30 : (i < 400) ? 85 : 50;
      if (!bus.lu_valid || lu_accepted) begin
        bus.lu_valid = ($urandom_range(99) < 50);
        bus.lu_addr  = 4'($urandom);
        bus.lu_data  = 16'($urandom);
      end
      bus.wb_we      = ($urandom_range(99) < wb_pct);
      bus.wb_addr    = 4'($urandom);
      bus.wb_data    = 16'($urandom);
      bus.issue_en   = ($urandom_range(99) < 25);
      bus.issue_addr = 4'($urandom);
      if (i == 300) do_reset();
      step();
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) step();
    @(negedge clk); #1;
    chk("writes_drained", 32'(wq.size()), 0);
    chk("model_fifo_drained", 32'(m_fifo.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
